// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {inst, pc, pc_next}
// with valid/ready on both sides and a single-cycle backend flush.
module inst_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_inst,
  input  logic [31:0]      enq_pc,
  input  logic [31:0]      enq_pc_next,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [31:0]      deq_inst,
  output logic [31:0]      deq_pc,
  output logic [31:0]      deq_pc_next,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W:0]     head_ptr;
  logic [PTR_W:0]     tail_ptr;
  logic               empty;
  logic               full;
  logic               enq_fire;
  logic               deq_fire;

  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_ptr[PTR_W-1:0] == tail_ptr[PTR_W-1:0]) &&
                 (head_ptr[PTR_W] != tail_ptr[PTR_W]);

  // Ready/valid come from pointer state only, so a full queue refuses
  // an enqueue even when the head is being popped in the same cycle.
  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign enq_fire  = enq_valid && enq_ready && !flush;
  assign deq_fire  = deq_valid && deq_ready && !flush;

  assign count = tail_ptr - head_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (enq_fire) tail_ptr <= tail_ptr + (PTR_W+1)'(1);
      if (deq_fire) head_ptr <= head_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[tail_ptr[PTR_W-1:0]] <= '{inst: enq_inst, pc: enq_pc, pc_next: enq_pc_next};
    end
  end

  assign deq_inst    = mem[head_ptr[PTR_W-1:0]].inst;
  assign deq_pc      = mem[head_ptr[PTR_W-1:0]].pc;
  assign deq_pc_next = mem[head_ptr[PTR_W-1:0]].pc_next;

endmodule

// File: doc/inst_queue.md
# inst_queue

Decoupling FIFO between the fetch stage and the backend decode (ID) stage. Fetch pushes one instruction per cycle (instruction word, PC, predicted next PC), and decode pops one per cycle through a valid/ready handshake. A backend flush empties the queue in one cycle so that wrong-path instructions never reach rename.

## Interface
- DEPTH, 16: number of entries; power of two, ≥ 2.
- PTR_W, $clog2(DEPTH): index width. Pointers carry one extra wrap bit (PTR_W+1 bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush  in  1  backend flush; synchronous, highest priority.
- enq_valid  in  1  fetch presents an instruction.
- enq_ready  out  1  queue can accept; equals !full.
- enq_inst  in  32  instruction word.
- enq_pc  in  32  instruction PC.
- enq_pc_next  in  32  predicted next PC.
- deq_valid  out  1  head entry valid; equals !empty.
- deq_ready  in  1  decode accepts the head.
- deq_inst  out  32  head instruction word.
- deq_pc  out  32  head PC.
- deq_pc_next  out  32  head predicted next PC.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

## Operation
- Storage: a DEPTH-entry circular array of {inst, pc, pc_next}, plus head_ptr and tail_ptr (PTR_W+1 bits each).
- Status:
  - empty = (head_ptr == tail_ptr).
  - full = index bits equal and wrap bits differ.
  - count = tail_ptr − head_ptr, modulo 2^(PTR_W+1).
- Enqueue fires when enq_valid && enq_ready && !flush:
  - write the entry at tail index;
  - tail_ptr += 1, wrapping naturally through the extra bit.
- Dequeue fires when deq_valid && deq_ready && !flush:
  - head_ptr += 1.
- Deq outputs are a combinational read of the array at head index. No same-cycle bypass from enq to deq.
- Enqueue and dequeue in the same cycle:
  - both pointers advance and count is unchanged;
  - legal at any occupancy except full (enq_ready=0) and empty (deq_valid=0).
- Flush:
  - next edge sets head_ptr = tail_ptr = 0;
  - any enq or deq in the flush cycle is discarded; enq_ready and deq_valid still show their pre-flush values that cycle;
  - array contents are not cleared.
- enq_ready depends only on state. It never depends combinationally on deq_ready; a full queue refuses enq even if a deq happens that cycle.
- When deq_valid=0, the deq data outputs are don't-care.
- The upstream must hold enq_* stable while enq_valid && !enq_ready. The queue holds deq_* stable while deq_valid && !deq_ready, except across a flush.

## Timing
- Reset (async assert, sync release):
  - head_ptr=0, tail_ptr=0, count=0;
  - deq_valid=0, enq_ready=1.
  - Array is not reset.
- Enqueue-to-dequeue latency: one cycle. An entry written at edge N shows deq_valid=1 in cycle N+1.
- Throughput: 1 enq plus 1 deq per cycle sustained when 0 < count < DEPTH.
- Flush asserted in cycle N gives deq_valid=0, enq_ready=1, count=0 in cycle N+1.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Fill and drain, DEPTH=4, deq_ready=0:
  - Enqueue 4 entries, pc = 0x1000, 0x1004, 0x1008, 0x100C.
  - Required: enq_ready=0 and count=4 after the 4th edge.
  - Then set deq_ready=1. Required: deq_pc reads 0x1000…0x100C in order, then deq_valid=0 and count=0.
- Wrap-around:
  - Run 10 enq/deq cycles with enq_inst = i.
  - Required: deq order 0..9, no loss or duplication, pointers wrap at least twice.
- Simultaneous enq and deq at count=2:
  - count stays 2.
  - The new entry appears after the two older ones.
- Full with deq:
  - At count=4, assert enq_valid=1 and deq_ready=1.
  - Required: enq rejected that cycle (enq_ready=0); count=3 next cycle; enq accepted the cycle after.
- Flush:
  - At count=3, assert flush together with enq_valid=1 and deq_ready=1.
  - Required next cycle: count=0, deq_valid=0, enq_ready=1.
  - A following enq of pc=0x2000 appears at deq_pc one cycle later.
- Async reset:
  - Assert rst mid-cycle at count=2.
  - Required: deq_valid=0 and count=0 before the next clock edge.
  - Operation resumes normally after release.
